// File: rtl/dsm_decimator.sv
// rtl/dsm_decimator.sv - third-order CIC decimator turning a 1-bit delta-sigma stream into signed PCM
module dsm_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_R     = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_bitstream,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    localparam int ACC_WIDTH = 3*LOG2_R + 2;
    localparam int SHIFT     = 3*LOG2_R - (DATA_WIDTH-1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] integ1, integ2, integ3;
    logic signed [ACC_WIDTH-1:0] sample, dly1, dly2, dly3;
    logic [LOG2_R-1:0]           dec_cnt;
    logic                        pending;
    logic [1:0]                  warm_cnt;

    logic signed [ACC_WIDTH-1:0] in_val;
    logic signed [ACC_WIDTH-1:0] integ1_nxt, integ2_nxt, integ3_nxt;
    logic signed [ACC_WIDTH-1:0] comb1, comb2, comb3, shifted;
    logic [DATA_WIDTH-1:0]       sat_data;
    logic                        tick;

    // Integrators chain on each other's new values, so the sample taken on a
    // tick already includes that cycle's input bit.
    assign in_val     = i_bitstream ? {{(ACC_WIDTH-1){1'b0}}, 1'b1} : {ACC_WIDTH{1'b1}};
    assign integ1_nxt = integ1 + in_val;
    assign integ2_nxt = integ2 + integ1_nxt;
    assign integ3_nxt = integ3 + integ2_nxt;
    assign tick       = i_en && (dec_cnt == {LOG2_R{1'b1}});

    assign comb1   = sample - dly1;
    assign comb2   = comb1 - dly2;
    assign comb3   = comb2 - dly3;
    assign shifted = comb3 >>> SHIFT;

    always_comb begin
        sat_data = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            integ1   <= '0;
            integ2   <= '0;
            integ3   <= '0;
            sample   <= '0;
            dly1     <= '0;
            dly2     <= '0;
            dly3     <= '0;
            dec_cnt  <= '0;
            pending  <= 1'b0;
            warm_cnt <= 2'd0;
            o_data   <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_en) begin
                integ1  <= integ1_nxt;
                integ2  <= integ2_nxt;
                integ3  <= integ3_nxt;
                dec_cnt <= dec_cnt + LOG2_R'(1);
            end
            // With R >= 2 a tick never lands in the cycle right after another tick.
            if (tick) begin
                sample  <= integ3_nxt;
                pending <= 1'b1;
            end else if (pending) begin
                dly1    <= sample;
                dly2    <= comb1;
                dly3    <= comb2;
                pending <= 1'b0;
                o_data  <= sat_data;
                if (warm_cnt == 2'd3) begin
                    o_valid <= 1'b1;
                end else begin
                    warm_cnt <= warm_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_decimator.sv
// tb/tb_dsm_decimator.sv - directed and reference-model checks for dsm_decimator
module tb_dsm_decimator;

    localparam int R  = 64;
    localparam int NT = 3*R - 2;
    localparam int NRAND = 10000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic        i_bitstream = 1'b0;
    logic [15:0] o_data;
    logic        o_valid;

    int checks = 0;
    int errors = 0;
    int h1 [R];
    int h2 [2*R-1];
    int h3 [NT];
    bit bits [NRAND];

    dsm_decimator #(.DATA_WIDTH(16), .LOG2_R(6)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_en(i_en),
        .i_bitstream(i_bitstream),
        .o_data(o_data),
        .o_valid(o_valid)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int data_s();
        return int'($signed(o_data));
    endfunction

    function automatic int ref_out(input int n);
        int acc = 0;
        for (int j = 0; j < NT; j++) begin
            if (n - j >= 0) acc += h3[j] * (bits[n-j] ? 1 : -1);
        end
        acc = acc >>> 3;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_en = 1'b0;
        i_bitstream = 1'b0;
        #1;
        check("rst_data", data_s(), 0);
        check("rst_valid", int'(o_valid), 0);
        repeat (2) @(negedge i_clk);
        check("rst_data_hold", data_s(), 0);
        i_rst_n = 1'b1;
    endtask

    task automatic run_pattern(input string tag, input int ncyc, input int plen,
                               input logic [3:0] pat, input bit toggle,
                               input int exp_data, input int exp_first, input int exp_space);
        int idx = 0;
        int first = -1;
        int last = -1;
        int nv = 0;
        logic [3:0] p = pat;
        for (int c = 1; c <= ncyc; c++) begin
            i_en = toggle ? ((c - 1) % 2 == 0) : 1'b1;
            i_bitstream = p[idx % plen];
            if (i_en) idx++;
            @(negedge i_clk);
            if (o_valid) begin
                check({tag, "_data"}, data_s(), exp_data);
                if (first < 0) first = c;
                else check({tag, "_space"}, c - last, exp_space);
                last = c;
                nv++;
            end
        end
        check({tag, "_first"}, first, exp_first);
        check({tag, "_count"}, nv, (ncyc - exp_first) / exp_space + 1);
    endtask

    initial begin
        int first;
        int m;

        for (int j = 0; j < R; j++) h1[j] = 1;
        for (int j = 0; j < 2*R-1; j++) begin
            h2[j] = 0;
            for (int a = 0; a < R; a++) if (j - a >= 0 && j - a < R) h2[j] += h1[a];
        end
        for (int j = 0; j < NT; j++) begin
            h3[j] = 0;
            for (int a = 0; a < R; a++) if (j - a >= 0 && j - a < 2*R-1) h3[j] += h2[j-a];
        end

        do_reset();
        run_pattern("ones", 700, 1, 4'b0001, 1'b0, 32767, 257, 64);
        do_reset();
        run_pattern("zeros", 700, 1, 4'b0000, 1'b0, -32768, 257, 64);
        do_reset();
        run_pattern("alt10", 700, 2, 4'b0001, 1'b0, 0, 257, 64);
        do_reset();
        run_pattern("p1110", 700, 4, 4'b0111, 1'b0, 16384, 257, 64);
        do_reset();
        run_pattern("en_tog", 1400, 1, 4'b0001, 1'b1, 32767, 512, 128);

        do_reset();
        run_pattern("pre_rst", 833, 1, 4'b0001, 1'b0, 32767, 257, 64);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_s(), 0);
        check("mid_rst_valid", int'(o_valid), 0);
        @(negedge i_clk);
        check("mid_rst_data_hold", data_s(), 0);
        i_rst_n = 1'b1;
        first = -1;
        for (int c = 1; c <= 400; c++) begin
            i_en = 1'b1;
            i_bitstream = 1'b1;
            @(negedge i_clk);
            if (c == 65) begin
                check("warm_data", data_s(), 5720);
                check("warm_valid", int'(o_valid), 0);
            end
            if (o_valid) begin
                if (first < 0) first = c;
                check("post_rst_data", data_s(), 32767);
            end
        end
        check("post_rst_first", first, 257);

        do_reset();
        for (int i = 0; i < NRAND; i++) bits[i] = 1'($urandom_range(0, 1));
        first = -1;
        m = 0;
        for (int c = 1; c <= NRAND; c++) begin
            i_en = 1'b1;
            i_bitstream = bits[c-1];
            @(negedge i_clk);
            if (o_valid) begin
                if (first < 0) first = c;
                check("rand_data", data_s(), ref_out((m + 4) * R - 1));
                m++;
            end
        end
        check("rand_first", first, 257);
        check("rand_count", m, (NRAND - 257) / 64 + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsm_decimator.md
DSM_DECIMATOR -- requirements
Module: dsm_decimator

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16, signed PCM output width.
REQ-002 The block SHALL expose parameter LOG2_R, default 6, log2 of decimation ratio R = 2^LOG2_R; legal only when 3*LOG2_R >= DATA_WIDTH-1.
REQ-003 The block SHALL derive localparam ACC_WIDTH = 3*LOG2_R + 2 for all integrator, comb and sample registers.
REQ-004 The block SHALL have i_clk  input  1  sole clock, all state updates on rising edge.
REQ-005 The block SHALL have i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have i_en  input  1  input-rate enable; bitstream consumed only in cycles with i_en=1.
REQ-007 The block SHALL have i_bitstream  input  1  delta-sigma bit, 1 maps to +1, 0 maps to -1.
REQ-008 The block SHALL have o_data  output  DATA_WIDTH  signed decimated PCM sample, held between updates.
REQ-009 The block SHALL have o_valid  output  1  single-cycle pulse marking a new o_data.

Function
REQ-010 The block SHALL implement a 3rd-order CIC (sinc^3) decimator: three cascaded integrators at input rate, decimate by R, three cascaded differential-delay-1 combs at output rate.
REQ-011 In each i_en=1 cycle, integrator 1 SHALL add the mapped input (+1/-1, sign-extended to ACC_WIDTH), integrator 2 SHALL add integrator 1's new value, integrator 3 SHALL add integrator 2's new value.
REQ-012 With i_en=0, integrators, decimation counter and i_bitstream SHALL be held/ignored.
REQ-013 Integrator and comb arithmetic SHALL be two's-complement modulo 2^ACC_WIDTH; wrap-around is intended and SHALL NOT be detected or saturated.
REQ-014 A decimation counter SHALL count i_en=1 cycles 0..R-1 and wrap to 0; a tick SHALL occur in the i_en=1 cycle where counter = R-1.
REQ-015 On the edge ending a tick cycle, a sample register SHALL capture integrator 3's updated value (including that cycle's input) and a pending flag SHALL set.
REQ-016 On the next edge, with pending set, the comb chain SHALL compute c1 = s - d1, c2 = c1 - d2, c3 = c2 - d3, update d1<=s, d2<=c1, d3<=c2, and clear pending, regardless of i_en.
REQ-017 On that same edge, o_data SHALL load sat(c3 >>> (3*LOG2_R - (DATA_WIDTH-1))), arithmetic shift, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-018 Latency: o_valid SHALL be high in the second clock cycle after the tick cycle, for exactly one cycle.
REQ-019 A 2-bit warm-up counter SHALL suppress o_valid for the first 3 comb updates after reset; o_data SHALL still update during warm-up.
REQ-020 After warm-up, o_valid SHALL pulse exactly once per R enabled input cycles.
REQ-021 A tick and a pending comb update in the same cycle cannot overlap for R>=2; LOG2_R >= 1 SHALL be required.

Reset
REQ-022 While i_rst_n=0, all integrators, counter, sample, comb delays, pending flag, warm-up counter SHALL be 0, o_data SHALL be 0, o_valid SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL clear all state immediately, discard any pending sample, and restart warm-up.
REQ-024 After release, the first enabled cycle SHALL be counter value 0.

Verification
REQ-025 Defaults, i_en=1, constant i_bitstream=1 -> first o_valid about 4*64+2 cycles after release, o_data=32767 on every valid.
REQ-026 Defaults, i_en=1, constant 0 -> o_data=-32768 on every valid.
REQ-027 Defaults, i_en=1, repeating 1,0 -> o_data=0; repeating 1,1,1,0 -> o_data=16384 on every valid.
REQ-028 Defaults, constant 1, i_en toggling every cycle -> o_data=32767, o_valid spacing 128 cycles.
REQ-029 Defaults, constant 1, reset pulsed after 10 valid outputs -> o_data=0, o_valid=0 during reset; after release, 3 suppressed updates, then 32767.
REQ-030 Defaults, i_en=1, 10000 random bits -> o_data matches a bit-exact sinc^3 reference model, including integrator wrap-around.
